axi_default_slave: RTL
======================

AXI_DEFAULT_SLAVE -- requirements
Module: axi_default_slave

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have parameter IDW, default 4, meaning AXI ID width.
REQ-004 SHALL have port i_clk, input, 1, the single clock.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have write-address ports: i_awid (IDW), i_awaddr (AW), i_awlen (8), i_awvalid (1) as inputs; o_awready (1) as output.
REQ-007 SHALL have write-data ports: i_wdata (DW), i_wstrb (DW/8), i_wlast (1), i_wvalid (1) as inputs; o_wready (1) as output.
REQ-008 SHALL have write-response ports: o_bid (IDW), o_bresp (2), o_bvalid (1) as outputs; i_bready (1) as input.
REQ-009 SHALL have read-address ports: i_arid (IDW), i_araddr (AW), i_arlen (8), i_arvalid (1) as inputs; o_arready (1) as output.
REQ-010 SHALL have read-data ports: o_rid (IDW), o_rdata (DW), o_rresp (2), o_rlast (1), o_rvalid (1) as outputs; i_rready (1) as input.

Function
REQ-011 SHALL act as the responder for every transaction the address decoder routes to the default slave (decode miss or access denied), ending each with DECERR (2'b11).
REQ-012 SHALL run write and read channels as independent FSMs; simultaneous AW and AR handshakes in one cycle SHALL both be accepted.
REQ-013 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP. In W_IDLE o_awready=1; on awvalid&&awready it SHALL capture awid and go to W_DATA.
REQ-014 In W_DATA, o_wready=1 and every beat SHALL be discarded. A beat with wvalid&&wlast SHALL move the FSM to W_RESP. Beat count and wstrb SHALL be ignored; wlast alone terminates the burst.
REQ-015 In W_RESP, o_bvalid=1, o_bresp=2'b11 and o_bid=captured ID, held stable until bready. On bvalid&&bready the FSM SHALL return to W_IDLE.
REQ-016 o_wready SHALL be 0 outside W_DATA, so W data arriving before its AW is stalled, not consumed.
REQ-017 Read FSM SHALL have states R_IDLE and R_DATA. In R_IDLE o_arready=1; on arvalid&&arready it SHALL capture arid and arlen, clear an 8-bit beat counter, and go to R_DATA.
REQ-018 In R_DATA, o_rvalid=1, o_rdata=0, o_rresp=2'b11 and o_rid=captured ID. o_rlast SHALL be 1 only when counter==captured len.
REQ-019 On rvalid&&rready with rlast=0, the counter SHALL increment. With rlast=1 the FSM SHALL return to R_IDLE. Exactly arlen+1 beats SHALL be produced.
REQ-020 Latency: first o_wready and first o_rvalid SHALL assert on the cycle after the address handshake. o_bvalid SHALL assert on the cycle after the wlast handshake.
REQ-021 A new AW/AR SHALL be accepted no earlier than the cycle after the previous B/last-R handshake, giving one outstanding transaction per direction.
REQ-022 All outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.

Reset
REQ-023 Assertion of i_rst_n=0 SHALL immediately force W_IDLE and R_IDLE, counter=0 and captured ID/len=0, including mid-burst.
REQ-024 During reset: o_awready=0, o_arready=0, o_wready=0, o_bvalid=0, o_rvalid=0, o_rlast=0, o_bresp=0, o_rresp=0, o_rdata=0, o_bid=0, o_rid=0. After release, o_awready and o_arready SHALL rise on the first clock edge.

Structure
REQ-025 Package axi_pkg SHALL hold the response constants (RESP_OKAY 2'b00, RESP_SLVERR 2'b10, RESP_DECERR 2'b11) and the write/read state enums.
REQ-026 The read-burst engine (R FSM plus counter) SHALL be sub-module axi_ds_rd; the write path SHALL stay inline.

Verification
REQ-027 AW id=3 len=3, 4 W beats with wlast on the 4th, bready=1 -> wready for exactly 4 beats, then one B with bid=3 and bresp=2'b11.
REQ-028 AR id=5 arlen=0 -> one R beat with rid=5, rdata=0, rresp=2'b11, rlast=1; arready re-asserts on the next cycle.
REQ-029 AR arlen=255 with rready toggled randomly -> exactly 256 beats, rlast only on the 256th, and the counter does not wrap early.
REQ-030 AW and AR in the same cycle, bready=0 held for 10 cycles -> bvalid/bid stable for all 10 cycles while the read burst completes independently.
REQ-031 i_wvalid driven before i_awvalid -> wready=0 until the cycle after the AW handshake.
REQ-032 i_rst_n pulsed low at beat 2 of an 8-beat read -> rvalid=0 immediately, and the next AR starts a fresh burst with rlast on beat arlen+1.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI response codes and channel state encodings for the default slave.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

endpackage

// File: rtl/axi_ds_rd.sv
// Read-burst engine of the default slave: accepts one AR, returns arlen+1 DECERR beats.
module axi_ds_rd
  import axi_pkg::*;
#(
  parameter int DW  = 32,
  parameter int IDW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [IDW-1:0] arid,
  input  logic [7:0]     arlen,
  input  logic           arvalid,
  output logic           arready,
  output logic [IDW-1:0] rid,
  output logic [DW-1:0]  rdata,
  output logic [1:0]     rresp,
  output logic           rlast,
  output logic           rvalid,
  input  logic           rready
);

  rd_state_t      state, state_nx;
  logic [7:0]     cnt;
  logic [7:0]     len_q;
  logic [IDW-1:0] id_q;
  logic           ar_hs;
  logic           r_hs;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;
  assign rid   = id_q;
  assign rdata = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= R_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Counter stops at len_q, so it can never wrap even for 256-beat bursts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      len_q <= '0;
      id_q  <= '0;
    end else if (ar_hs) begin
      cnt   <= '0;
      len_q <= arlen;
      id_q  <= arid;
    end else if (r_hs && !rlast) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    arready  = 1'b0;
    rvalid   = 1'b0;
    rlast    = 1'b0;
    rresp    = RESP_OKAY;
    case (state)
      R_IDLE: begin
        arready = en;
        if (arvalid && en) state_nx = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        rresp  = RESP_DECERR;
        rlast  = (cnt == len_q);
        if (rready && (cnt == len_q)) state_nx = R_IDLE;
      end
      default: state_nx = R_IDLE;
    endcase
  end

endmodule

// File: rtl/axi_default_slave.sv
// AXI default slave: terminates every decode-miss transaction with DECERR, one outstanding per direction.
module axi_default_slave
  import axi_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int IDW = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [IDW-1:0] i_awid,
  input  logic [AW-1:0]  i_awaddr,
  input  logic [7:0]     i_awlen,
  input  logic           i_awvalid,
  output logic           o_awready,
  input  logic [DW-1:0]  i_wdata,
  input  logic [DW/8-1:0] i_wstrb,
  input  logic           i_wlast,
  input  logic           i_wvalid,
  output logic           o_wready,
  output logic [IDW-1:0] o_bid,
  output logic [1:0]     o_bresp,
  output logic           o_bvalid,
  input  logic           i_bready,
  input  logic [IDW-1:0] i_arid,
  input  logic [AW-1:0]  i_araddr,
  input  logic [7:0]     i_arlen,
  input  logic           i_arvalid,
  output logic           o_arready,
  output logic [IDW-1:0] o_rid,
  output logic [DW-1:0]  o_rdata,
  output logic [1:0]     o_rresp,
  output logic           o_rlast,
  output logic           o_rvalid,
  input  logic           i_rready
);

  wr_state_t      wr_state, wr_state_nx;
  logic [IDW-1:0] bid_q;
  logic           alive;
  logic           unused_inputs;

  // Address, length, data and strobes carry no meaning for a DECERR responder
  assign unused_inputs = ^{i_awaddr, i_awlen, i_wdata, i_wstrb, i_araddr};

  // Holds the ready outputs low during reset and for the edge that releases it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_state <= W_IDLE;
      bid_q    <= '0;
    end else begin
      wr_state <= wr_state_nx;
      if (i_awvalid && o_awready) bid_q <= i_awid;
    end
  end

  assign o_bid = bid_q;

  always_comb begin
    wr_state_nx = wr_state;
    o_awready   = 1'b0;
    o_wready    = 1'b0;
    o_bvalid    = 1'b0;
    o_bresp     = RESP_OKAY;
    case (wr_state)
      W_IDLE: begin
        o_awready = alive;
        if (i_awvalid && alive) wr_state_nx = W_DATA;
      end
      W_DATA: begin
        o_wready = 1'b1;
        if (i_wvalid && i_wlast) wr_state_nx = W_RESP;
      end
      W_RESP: begin
        o_bvalid = 1'b1;
        o_bresp  = RESP_DECERR;
        if (i_bready) wr_state_nx = W_IDLE;
      end
      default: wr_state_nx = W_IDLE;
    endcase
  end

  axi_ds_rd #(
    .DW  (DW),
    .IDW (IDW)
  ) u_rd (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .en      (alive),
    .arid    (i_arid),
    .arlen   (i_arlen),
    .arvalid (i_arvalid),
    .arready (o_arready),
    .rid     (o_rid),
    .rdata   (o_rdata),
    .rresp   (o_rresp),
    .rlast   (o_rlast),
    .rvalid  (o_rvalid),
    .rready  (i_rready)
  );

endmodule
